regfile_access_ctrl: RTL and testbench

- Sequences and shares the single strobe-driven register file between three requesters: decode operand reads, writeback writes, and a debug port.
- The register file samples addresses, enables and write data on the rising edge of its strobe. This block generates that strobe from the core clock and merges one read with one write per strobe.
- It forwards same-strobe write data to the read result, suppresses writes to x0, and returns read data with fixed latency.
- It sits between decode/writeback/debug logic and the register file.

---
 rtl/regfile_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller.
// Shares one strobe-driven register file between decode operand reads,
// writeback writes and a debug port. Each transaction takes four cycles
// (IDLE grant, SETUP, STROBE, CAPTURE). One read is merged with one write
// per strobe. Same-strobe write data is forwarded to the read result, x0
// writes are suppressed, and x0 reads return zero.
module regfile_access_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  output logic            dec_resp_valid,
  output logic [XLEN-1:0] dec_rs1_value,
  output logic [XLEN-1:0] dec_rs2_value,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_value,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_resp_valid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            rf_req,
  output logic            rf_rs_read_n,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic [AW-1:0]   rf_rd,
  output logic            rf_rd_write_n,
  output logic [XLEN-1:0] rf_rd_value,
  input  logic [XLEN-1:0] rf_rs1_value,
  input  logic [XLEN-1:0] rf_rs2_value
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} state_t;

  state_t          state_reg, state_next;
  logic            rr_reg;          // 1 = debug wins the next contended read slot
  logic            strobe_reg;      // register-file strobe, kept in a flop to stay glitch-free
  logic            rd_grant_reg;    // a read owns this transaction
  logic            rd_is_dbg_reg;   // the read belongs to the debug port
  logic            wr_grant_reg;    // a write owns this transaction
  logic            dbg_wr_reg;      // the write belongs to the debug port
  logic [AW-1:0]   rs1_reg, rs2_reg, rd_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] dec_rs1_hold, dec_rs2_hold, dbg_rdata_hold;

  logic            dbg_rd_pend, dbg_wr_pend;
  logic            grant_dec, grant_dbg_rd, grant_dbg_wr, grant_wb, any_grant;
  logic            in_txn, capture;
  logic            fwd1, fwd2;
  logic [XLEN-1:0] rs1_result, rs2_result, dbg_result;

  // Arbitration of the read slot (round-robin) and write slot (debug first) in IDLE
  always_comb begin
    dbg_rd_pend  = dbg_valid & ~dbg_we;
    dbg_wr_pend  = dbg_valid & dbg_we;
    grant_dec    = 1'b0;
    grant_dbg_rd = 1'b0;
    grant_dbg_wr = 1'b0;
    grant_wb     = 1'b0;
    if (state_reg == IDLE) begin
      if (dec_valid && dbg_rd_pend) begin
        grant_dec    = ~rr_reg;
        grant_dbg_rd = rr_reg;
      end else begin
        grant_dec    = dec_valid;
        grant_dbg_rd = dbg_rd_pend;
      end
      grant_dbg_wr = dbg_wr_pend;
      grant_wb     = wb_valid & ~dbg_wr_pend;
    end
    any_grant = grant_dec | grant_dbg_rd | grant_dbg_wr | grant_wb;
  end

  assign dec_ready = grant_dec;
  assign wb_ready  = grant_wb;
  assign dbg_ready = grant_dbg_rd | grant_dbg_wr;

  // Next-state sequencing: grant -> setup -> strobe -> capture -> idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_grant) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and strobe flop; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      strobe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= (state_reg == SETUP);
    end
  end

  // Capture the granted payloads; unused address/data fields are zeroed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg        <= 1'b0;
      rd_grant_reg  <= 1'b0;
      rd_is_dbg_reg <= 1'b0;
      wr_grant_reg  <= 1'b0;
      dbg_wr_reg    <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      wdata_reg     <= '0;
    end else if (any_grant) begin
      rd_grant_reg  <= grant_dec | grant_dbg_rd;
      rd_is_dbg_reg <= grant_dbg_rd;
      wr_grant_reg  <= grant_dbg_wr | grant_wb;
      dbg_wr_reg    <= grant_dbg_wr;
      rs1_reg       <= grant_dec ? dec_rs1 : (grant_dbg_rd ? dbg_addr : '0);
      rs2_reg       <= grant_dec ? dec_rs2 : '0;
      rd_reg        <= grant_dbg_wr ? dbg_addr : (grant_wb ? wb_rd : '0);
      wdata_reg     <= grant_dbg_wr ? dbg_wdata : (grant_wb ? wb_value : '0);
      if (grant_dec | grant_dbg_rd) rr_reg <= ~rr_reg;
    end
  end

  // Register-file interface is only active between grant and capture
  assign in_txn        = (state_reg != IDLE);
  assign capture       = (state_reg == CAPTURE);
  assign rf_req        = strobe_reg;
  assign rf_rs_read_n  = ~(in_txn & rd_grant_reg);
  assign rf_rd_write_n = ~(in_txn & wr_grant_reg & (rd_reg != '0));
  assign rf_rs1        = (in_txn & rd_grant_reg) ? rs1_reg : '0;
  assign rf_rs2        = (in_txn & rd_grant_reg) ? rs2_reg : '0;
  assign rf_rd         = (in_txn & wr_grant_reg) ? rd_reg : '0;
  assign rf_rd_value   = (in_txn & wr_grant_reg) ? wdata_reg : '0;

  // The register file returns pre-write values, so merged writes are forwarded
  assign fwd1       = wr_grant_reg & (rd_reg != '0) & (rd_reg == rs1_reg);
  assign fwd2       = wr_grant_reg & (rd_reg != '0) & (rd_reg == rs2_reg);
  assign rs1_result = (rs1_reg == '0) ? '0 : (fwd1 ? wdata_reg : rf_rs1_value);
  assign rs2_result = (rs2_reg == '0) ? '0 : (fwd2 ? wdata_reg : rf_rs2_value);
  assign dbg_result = (rd_grant_reg & rd_is_dbg_reg) ? rs1_result : '0;

  assign dec_resp_valid = capture & rd_grant_reg & ~rd_is_dbg_reg;
  assign dbg_resp_valid = capture & ((rd_grant_reg & rd_is_dbg_reg) | dbg_wr_reg);
  assign dec_rs1_value  = dec_resp_valid ? rs1_result : dec_rs1_hold;
  assign dec_rs2_value  = dec_resp_valid ? rs2_result : dec_rs2_hold;
  assign dbg_rdata      = dbg_resp_valid ? dbg_result : dbg_rdata_hold;

  // Response data holds its last value until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_rs1_hold   <= '0;
      dec_rs2_hold   <= '0;
      dbg_rdata_hold <= '0;
    end else begin
      if (dec_resp_valid) begin
        dec_rs1_hold <= rs1_result;
        dec_rs2_hold <= rs2_result;
      end
      if (dbg_resp_valid) dbg_rdata_hold <= dbg_result;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: directed scenarios followed by random
// traffic, checked against an architectural register model.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0, wb_valid = 1'b0, dbg_valid = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, wb_rd = '0, dbg_addr = '0;
  logic [31:0] wb_value = '0, dbg_wdata = '0;
  logic        dec_ready, dec_resp_valid, wb_ready, dbg_ready, dbg_resp_valid;
  logic [31:0] dec_rs1_value, dec_rs2_value, dbg_rdata;
  logic        rf_req, rf_rs_read_n, rf_rd_write_n;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_rd_value;
  logic [31:0] rf_rs1_value = '0, rf_rs2_value = '0;

  logic [31:0] mem [32];       // the physical register file
  logic [31:0] ref_regs [32];  // architectural register contents expected
  logic        fav_dbg = 1'b0; // model: debug wins next contended read
  int          n_checks = 0, n_pass = 0, n_txn = 0;

  regfile_access_ctrl #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_resp_valid(dec_resp_valid), .dec_rs1_value(dec_rs1_value), .dec_rs2_value(dec_rs2_value),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_value(wb_value),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata),
    .rf_req(rf_req), .rf_rs_read_n(rf_rs_read_n), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_rd_write_n(rf_rd_write_n), .rf_rd_value(rf_rd_value),
    .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value)
  );

  always #5 clk = ~clk;

  // Register-file behaviour: sample on the strobe edge, return pre-write values
  always @(posedge rf_req) begin
    if (!rf_rs_read_n) begin
      rf_rs1_value = mem[rf_rs1];
      rf_rs2_value = mem[rf_rs2];
    end
    if (!rf_rd_write_n) mem[rf_rd] = rf_rd_value;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : ref_regs[a];
  endfunction

  // One IDLE cycle plus, if anything is granted, the full transaction
  task automatic step();
    logic e_dec, e_dbgr, e_dbgw, e_wb, w_any, w_real;
    logic [4:0]  w_addr;
    logic [31:0] w_data, e1, e2, edbg;
    @(negedge clk);
    e_dbgw = dbg_valid && dbg_we;
    if (dec_valid && dbg_valid && !dbg_we) begin
      e_dec  = !fav_dbg;
      e_dbgr = fav_dbg;
    end else begin
      e_dec  = dec_valid;
      e_dbgr = dbg_valid && !dbg_we;
    end
    e_wb = wb_valid && !e_dbgw;
    chk("dec_ready", 32'(dec_ready), 32'(e_dec));
    chk("wb_ready", 32'(wb_ready), 32'(e_wb));
    chk("dbg_ready", 32'(dbg_ready), 32'(e_dbgr || e_dbgw));
    if (!(e_dec || e_dbgr || e_dbgw || e_wb)) begin
      @(posedge clk); #1;
      return;
    end
    if (e_dec || e_dbgr) fav_dbg = !fav_dbg;
    w_any  = e_dbgw || e_wb;
    w_addr = e_dbgw ? dbg_addr : wb_rd;
    w_data = e_dbgw ? dbg_wdata : wb_value;
    w_real = w_any && (w_addr != 5'd0);
    // A read in the same transaction observes the new write
    if (w_real) ref_regs[w_addr] = w_data;
    e1   = ref_rd(dec_rs1);
    e2   = ref_rd(dec_rs2);
    edbg = e_dbgr ? ref_rd(dbg_addr) : 32'd0;
    @(posedge clk); #1;
    if (e_dec) dec_valid = 1'b0;
    if (e_wb) wb_valid = 1'b0;
    if (e_dbgr || e_dbgw) dbg_valid = 1'b0;
    @(negedge clk);
    chk("setup_rf_req", 32'(rf_req), 32'd0);
    chk("setup_rs_read_n", 32'(rf_rs_read_n), 32'(!(e_dec || e_dbgr)));
    chk("setup_rd_write_n", 32'(rf_rd_write_n), 32'(!w_real));
    @(negedge clk);
    chk("strobe_rf_req", 32'(rf_req), 32'd1);
    chk("strobe_rd_write_n", 32'(rf_rd_write_n), 32'(!w_real));
    @(negedge clk);
    chk("capture_rf_req", 32'(rf_req), 32'd0);
    chk("dec_resp_valid", 32'(dec_resp_valid), 32'(e_dec));
    chk("dbg_resp_valid", 32'(dbg_resp_valid), 32'(e_dbgr || e_dbgw));
    if (e_dec) begin
      chk("dec_rs1_value", dec_rs1_value, e1);
      chk("dec_rs2_value", dec_rs2_value, e2);
    end
    if (e_dbgr || e_dbgw) chk("dbg_rdata", dbg_rdata, edbg);
    @(posedge clk); #1;
    n_txn++;
    $display("txn %0d: dec=%0b wb=%0b dbg_rd=%0b dbg_wr=%0b waddr=%0d wdata=%h rs1=%h rs2=%h dbg=%h",
             n_txn, e_dec, e_wb, e_dbgr, e_dbgw, w_addr, w_data, e1, e2, edbg);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]      = $urandom;
      ref_regs[i] = mem[i];
    end
    mem[0]      = 32'hBAD0_BAD0;
    mem[3]      = 32'h11; ref_regs[3] = 32'h11;
    mem[4]      = 32'h22; ref_regs[4] = 32'h22;

    // Reset state
    #2;
    chk("rst_rf_req", 32'(rf_req), 32'd0);
    chk("rst_rs_read_n", 32'(rf_rs_read_n), 32'd1);
    chk("rst_rd_write_n", 32'(rf_rd_write_n), 32'd1);
    chk("rst_dec_resp_valid", 32'(dec_resp_valid), 32'd0);
    chk("rst_dbg_resp_valid", 32'(dbg_resp_valid), 32'd0);
    chk("rst_dec_rs1_value", dec_rs1_value, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic decode read
    dec_valid = 1'b1; dec_rs1 = 5'd3; dec_rs2 = 5'd4;
    step();

    // Merged decode read and writeback to the same register, then re-read
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd3;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_value = 32'hDEADBEEF;
    step();
    dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd0;
    step();

    // Write to x0 is acknowledged but suppressed; x0 reads as zero
    wb_valid = 1'b1; wb_rd = 5'd0; wb_value = 32'h1234;
    step();
    dec_valid = 1'b1; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    step();
    chk("x0_untouched", mem[0], 32'hBAD0_BAD0);

    // Contending decode and debug reads alternate
    for (int k = 0; k < 4; k++) begin
      dec_valid = 1'b1; dec_rs1 = 5'd1; dec_rs2 = 5'd2;
      dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
      step();
    end
    dbg_valid = 1'b0; dec_valid = 1'b0;
    step();

    // Debug write blocks a pending writeback for one transaction
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hCAFE;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_value = 32'h0BAD_F00D;
    step();
    step();
    chk("rf9", mem[9], 32'hCAFE);
    chk("rf10", mem[10], 32'h0BAD_F00D);
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    step();
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
    step();

    // Reset during STROBE drops the transaction
    dec_valid = 1'b1; dec_rs1 = 5'd3; dec_rs2 = 5'd4;
    @(negedge clk);
    chk("mid_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    dec_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_strobe_rf_req", 32'(rf_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_req", 32'(rf_req), 32'd0);
    chk("mid_rst_dec_rs1_value", dec_rs1_value, 32'd0);
    fav_dbg = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_dec_resp_valid", 32'(dec_resp_valid), 32'd0);
      chk("post_rst_rf_req", 32'(rf_req), 32'd0);
    end
    @(posedge clk); #1;
    // Pointer favours decode again after reset
    dec_valid = 1'b1; dec_rs1 = 5'd4; dec_rs2 = 5'd3;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    step();
    step();

    // Random traffic; pending requests hold their payload until granted
    for (int i = 0; i < 60; i++) begin
      if (!dec_valid && ($urandom_range(0, 1) == 1)) begin
        dec_valid = 1'b1;
        dec_rs1 = 5'($urandom_range(0, 7));
        dec_rs2 = 5'($urandom_range(0, 31));
      end
      if (!wb_valid && ($urandom_range(0, 1) == 1)) begin
        wb_valid = 1'b1;
        wb_rd = 5'($urandom_range(0, 7));
        wb_value = $urandom;
      end
      if (!dbg_valid && ($urandom_range(0, 2) == 0)) begin
        dbg_valid = 1'b1;
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 5'($urandom_range(0, 7));
        dbg_wdata = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
